// File: rtl/sys_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_master_pkg
// Description : Shared types and helpers for the UART command initiator:
//               command encodings, frame header bytes, frame/response
//               length lookups and the controller state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_cmd_master_pkg;

  // Command type as carried on cmd_type
  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // First byte of every frame identifies the command
  localparam logic [7:0] c_hdr_rf_wr   = 8'hAA;
  localparam logic [7:0] c_hdr_rf_rd   = 8'hBB;
  localparam logic [7:0] c_hdr_alu_op  = 8'hCC;
  localparam logic [7:0] c_hdr_alu_nop = 8'hDD;

  // Number of bytes transmitted for a command, header included
  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      CMD_RF_WR:  return 3'd3;
      CMD_RF_RD:  return 3'd2;
      CMD_ALU_OP: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

  // Number of response bytes expected back for a command
  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      CMD_RF_WR:  return 2'd0;
      CMD_RF_RD:  return 2'd1;
      default:    return 2'd2;
    endcase
  endfunction

endpackage : sys_cmd_master_pkg
`default_nettype wire

// File: rtl/sys_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_master_if
// Description : Command request/response, UART TX byte and UART RX byte
//               signal bundle of the command initiator. The master modport
//               is the initiator's view, the slave modport the host/UART view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_cmd_master_if #(
  parameter int DATA_WIDTH = 8
);

  // Command request
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_type;
  logic [DATA_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH-1:0]   cmd_opb;
  logic [3:0]              cmd_fun;

  // UART transmitter byte stream
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  // UART receiver byte stream
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;

  // Completion
  logic                    rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic                    rsp_timeout;
  logic                    busy;

  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opb, cmd_fun,
    input  tx_ready, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_valid,
    output rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opb, cmd_fun,
    output tx_ready, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_valid,
    input  rsp_valid, rsp_data, rsp_timeout, busy
  );

endinterface : sys_cmd_master_if
`default_nettype wire

// File: rtl/sys_cmd_master_timeout.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_master_timeout
// Description : Idle-cycle counter for response collection. Cleared by
//               i_clr, advances while i_en, and flags o_expired once it has
//               reached TIMEOUT_CYCLES-1. It saturates there so a held
//               expiry cannot wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_cmd_master_timeout #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WD          = 16
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expired
);

  localparam logic [TO_WD-1:0] c_limit = TO_WD'(TIMEOUT_CYCLES - 1);

  logic [TO_WD-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == c_limit);
  assign o_expired  = w_at_limit;

  // Idle counter: clear has priority, then count up to the limit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + TO_WD'(1);
    end
  end

endmodule : sys_cmd_master_timeout
`default_nettype wire

// File: rtl/sys_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_master
// Description : Host-side command initiator. Accepts one command, sends its
//               frame byte by byte to a UART transmitter, collects the
//               response bytes from a UART receiver and reports the response
//               word, or a timeout if the receiver goes quiet for too long.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_cmd_master
  import sys_cmd_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WD          = 16
) (
  input wire logic          CLK,
  input wire logic          RST,
  sys_cmd_master_if.master  bus
);

  state_e                  r_state;
  state_e                  w_next_state;

  cmd_type_e               r_type;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_opb;
  logic [3:0]              r_fun;
  logic [2:0]              r_idx;
  logic [1:0]              r_rcnt;
  logic [2*DATA_WIDTH-1:0] r_rsp_data;
  logic                    r_to_flag;

  logic                    w_accept;
  logic                    w_tx_fire;
  logic                    w_last_byte;
  logic                    w_rx_take;
  logic                    w_rsp_done;
  logic                    w_expired;
  logic                    w_to_fire;
  logic                    w_to_clr;
  logic [DATA_WIDTH-1:0]   w_fun_byte;
  logic [DATA_WIDTH-1:0]   w_frame_byte;

  // Handshake qualifiers; rx bytes count only while waiting for a response
  assign w_accept    = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_tx_fire   = (r_state == ST_SEND) && bus.tx_ready;
  assign w_last_byte = (r_idx == (frame_len(r_type) - 3'd1));
  assign w_rx_take   = (r_state == ST_WAIT_RSP) && bus.rx_valid;
  assign w_rsp_done  = w_rx_take && ((r_rcnt + 2'd1) == rsp_len(r_type));
  // A byte arriving on the expiry cycle wins over the timeout
  assign w_to_fire   = (r_state == ST_WAIT_RSP) && !bus.rx_valid && w_expired;
  // Counter is held at zero outside WAIT_RSP so it starts fresh on entry
  assign w_to_clr    = (r_state != ST_WAIT_RSP) || bus.rx_valid;

  sys_cmd_master_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WD          (TO_WD)
  ) u_timeout (
    .CLK       (CLK),
    .RST       (RST),
    .i_clr     (w_to_clr),
    .i_en      (r_state == ST_WAIT_RSP),
    .o_expired (w_expired)
  );

  // Frame byte selection from the latched command and byte index
  always_comb begin
    w_fun_byte      = '0;
    w_fun_byte[3:0] = r_fun;
    w_frame_byte    = '0;
    case (r_type)
      CMD_RF_WR: begin
        case (r_idx)
          3'd0:    w_frame_byte = DATA_WIDTH'(c_hdr_rf_wr);
          3'd1:    w_frame_byte = r_addr;
          default: w_frame_byte = r_wdata;
        endcase
      end
      CMD_RF_RD: begin
        case (r_idx)
          3'd0:    w_frame_byte = DATA_WIDTH'(c_hdr_rf_rd);
          default: w_frame_byte = r_addr;
        endcase
      end
      CMD_ALU_OP: begin
        case (r_idx)
          3'd0:    w_frame_byte = DATA_WIDTH'(c_hdr_alu_op);
          3'd1:    w_frame_byte = r_wdata;
          3'd2:    w_frame_byte = r_opb;
          default: w_frame_byte = w_fun_byte;
        endcase
      end
      default: begin
        case (r_idx)
          3'd0:    w_frame_byte = DATA_WIDTH'(c_hdr_alu_nop);
          default: w_frame_byte = w_fun_byte;
        endcase
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_tx_fire && w_last_byte) begin
          w_next_state = (rsp_len(r_type) == 2'd0) ? ST_DONE : ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (w_rsp_done || w_to_fire) begin
          w_next_state = ST_DONE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Command latch, byte index, response assembly and timeout flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_type     <= CMD_RF_WR;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_opb      <= '0;
      r_fun      <= '0;
      r_idx      <= '0;
      r_rcnt     <= '0;
      r_rsp_data <= '0;
      r_to_flag  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type     <= cmd_type_e'(bus.cmd_type);
        r_addr     <= bus.cmd_addr;
        r_wdata    <= bus.cmd_wdata;
        r_opb      <= bus.cmd_opb;
        r_fun      <= bus.cmd_fun;
        r_idx      <= '0;
        r_rcnt     <= '0;
        r_rsp_data <= '0;
        r_to_flag  <= 1'b0;
      end
      if (w_tx_fire) begin
        r_idx <= r_idx + 3'd1;
      end
      // Response arrives LSB first
      if (w_rx_take) begin
        if (r_rcnt == 2'd0) begin
          r_rsp_data[DATA_WIDTH-1:0] <= bus.rx_data;
        end else begin
          r_rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.rx_data;
        end
        r_rcnt <= r_rcnt + 2'd1;
      end
      if (w_to_fire) begin
        r_to_flag <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.tx_valid    = (r_state == ST_SEND);
  assign bus.tx_data     = (r_state == ST_SEND) ? w_frame_byte : '0;
  assign bus.rsp_valid   = (r_state == ST_DONE);
  assign bus.rsp_timeout = (r_state == ST_DONE) && r_to_flag;
  assign bus.rsp_data    = r_rsp_data;

endmodule : sys_cmd_master
`default_nettype wire

// File: tb/tb_sys_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_cmd_master
// Description : Directed self-checking bench for sys_cmd_master with a
//               short response timeout (64 idle cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_cmd_master;
  import sys_cmd_master_pkg::*;

  localparam int c_to = 64;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  sys_cmd_master_if #(.DATA_WIDTH(8)) bus ();

  sys_cmd_master #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (c_to),
    .TO_WD          (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: count, and report any mismatch
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Present a command in the current (IDLE) cycle; returns in the first SEND cycle
  task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [7:0] w,
                       input logic [7:0] b, input logic [3:0] f, input bit hold);
    check_value("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_type  = t;
    bus.cmd_addr  = a;
    bus.cmd_wdata = w;
    bus.cmd_opb   = b;
    bus.cmd_fun   = f;
    bus.cmd_valid = 1'b1;
    cyc();
    if (!hold) bus.cmd_valid = 1'b0;
    check_value("busy_after_accept", bus.busy, 1);
    check_value("rsp_data_cleared", bus.rsp_data, 0);
  endtask

  // Consume a frame, checking every cycle's byte; toggle=1 stalls on even cycles
  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input bit toggle);
    logic [7:0] exp_b [4];
    int i;
    int k;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
    i = 0;
    k = 0;
    while (i < n && k < 24) begin
      check_value($sformatf("tx_valid[%0d]", i), bus.tx_valid, 1);
      check_value($sformatf("tx_data[%0d]", i), bus.tx_data, exp_b[i]);
      bus.tx_ready = toggle ? k[0] : 1'b1;
      cyc();
      if (bus.tx_ready) i++;
      k++;
    end
    check_value("frame_complete", i, n);
    bus.tx_ready = 1'b1;
  endtask

  // One-cycle receiver pulse
  task automatic rx_byte(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    cyc();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int early;
    n_checks = 0;
    n_errors = 0;
    RST = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_addr = 8'h00;
    bus.cmd_wdata = 8'h00; bus.cmd_opb = 8'h00; bus.cmd_fun = 4'h0;
    bus.tx_ready  = 1'b1; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;

    // ---- Reset state ----
    cyc(); cyc();
    check_value("rst_tx_valid", bus.tx_valid, 0);
    check_value("rst_tx_data", bus.tx_data, 0);
    check_value("rst_rsp_valid", bus.rsp_valid, 0);
    check_value("rst_rsp_data", bus.rsp_data, 0);
    check_value("rst_rsp_timeout", bus.rsp_timeout, 0);
    check_value("rst_busy", bus.busy, 0);
    check_value("rst_cmd_ready", bus.cmd_ready, 1);
    RST = 1'b1;
    cyc();

    // ---- RF_WR: AA,05,3C back to back, completion right after the last byte ----
    issue(CMD_RF_WR, 8'h05, 8'h3C, 8'h00, 4'h0, 1'b0);
    check_value("wr_cmd_ready_low", bus.cmd_ready, 0);
    send_frame(3, 8'hAA, 8'h05, 8'h3C, 8'h00, 1'b0);
    check_value("wr_rsp_valid", bus.rsp_valid, 1);
    check_value("wr_rsp_timeout", bus.rsp_timeout, 0);
    check_value("wr_rsp_data", bus.rsp_data, 32'h0000);
    cyc();
    check_value("wr_rsp_pulse_end", bus.rsp_valid, 0);
    check_value("wr_back_idle", bus.cmd_ready, 1);

    // ---- RF_RD: BB,02; reply 0x81 after 50 quiet cycles (inside the 64-cycle limit) ----
    issue(CMD_RF_RD, 8'h02, 8'h00, 8'h00, 4'h0, 1'b0);
    send_frame(2, 8'hBB, 8'h02, 8'h00, 8'h00, 1'b0);
    check_value("rd_tx_idle_in_wait", bus.tx_valid, 0);
    early = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid) early++;
      cyc();
    end
    check_value("rd_no_early_rsp", early, 0);
    rx_byte(8'h81);
    check_value("rd_rsp_valid", bus.rsp_valid, 1);
    check_value("rd_rsp_timeout", bus.rsp_timeout, 0);
    check_value("rd_rsp_data", bus.rsp_data, 32'h0081);
    cyc();
    check_value("rd_rsp_pulse_end", bus.rsp_valid, 0);

    // ---- ALU_OP with stalling transmitter; 2nd byte lands on the expiry cycle ----
    issue(CMD_ALU_OP, 8'h00, 8'h0A, 8'h14, 4'h0, 1'b0);
    send_frame(4, 8'hCC, 8'h0A, 8'h14, 8'h00, 1'b1);
    rx_byte(8'h1E);
    // Counter reads 0 now; after 63 more quiet cycles it sits at 63 = limit
    early = 0;
    for (int i = 0; i < c_to - 1; i++) begin
      if (bus.rsp_valid) early++;
      cyc();
    end
    check_value("alu_no_early_rsp", early + bus.rsp_valid, 0);
    rx_byte(8'h00);
    check_value("alu_rsp_valid", bus.rsp_valid, 1);
    check_value("alu_rsp_timeout", bus.rsp_timeout, 0);
    check_value("alu_rsp_data", bus.rsp_data, 32'h001E);
    cyc();

    // ---- ALU_NOP, one byte then silence: timeout after 64 quiet cycles ----
    issue(CMD_ALU_NOP, 8'h00, 8'h00, 8'h00, 4'h2, 1'b0);
    send_frame(2, 8'hDD, 8'h02, 8'h00, 8'h00, 1'b0);
    rx_byte(8'h55);
    early = 0;
    for (int i = 0; i < c_to; i++) begin
      if (bus.rsp_valid) early++;
      cyc();
    end
    check_value("nop_no_early_rsp", early, 0);
    check_value("nop_rsp_valid", bus.rsp_valid, 1);
    check_value("nop_rsp_timeout", bus.rsp_timeout, 1);
    check_value("nop_rsp_data", bus.rsp_data, 32'h0055);
    cyc();
    check_value("nop_rsp_pulse_end", bus.rsp_valid, 0);
    check_value("nop_timeout_pulse_end", bus.rsp_timeout, 0);

    // ---- Stray rx in SEND, cmd_valid held while busy ----
    issue(CMD_RF_RD, 8'h07, 8'h00, 8'h00, 4'h0, 1'b1);
    bus.cmd_type = CMD_ALU_NOP;
    bus.cmd_fun  = 4'h3;
    check_value("stray_cmd_ready_low", bus.cmd_ready, 0);
    check_value("stray_hdr_held", bus.tx_data, 8'hBB);
    bus.tx_ready = 1'b0;
    rx_byte(8'h99);
    bus.tx_ready = 1'b1;
    send_frame(2, 8'hBB, 8'h07, 8'h00, 8'h00, 1'b0);
    cyc(); cyc();
    check_value("stray_busy_in_wait", bus.busy, 1);
    rx_byte(8'h42);
    check_value("stray_rsp_valid", bus.rsp_valid, 1);
    check_value("stray_rsp_data", bus.rsp_data, 32'h0042);
    cyc();
    check_value("held_cmd_ready_back", bus.cmd_ready, 1);
    cyc();
    bus.cmd_valid = 1'b0;
    send_frame(2, 8'hDD, 8'h03, 8'h00, 8'h00, 1'b0);
    rx_byte(8'h34);
    rx_byte(8'h12);
    check_value("held_rsp_valid", bus.rsp_valid, 1);
    check_value("held_rsp_data", bus.rsp_data, 32'h1234);
    cyc();
    rx_byte(8'hEE);
    check_value("idle_rx_ignored", bus.rsp_data, 32'h1234);
    check_value("idle_rx_no_busy", bus.busy, 0);

    // ---- Reset during the 2nd ALU_OP byte ----
    issue(CMD_ALU_OP, 8'h00, 8'h33, 8'h44, 4'h5, 1'b0);
    check_value("rstmid_byte0", bus.tx_data, 8'hCC);
    cyc();
    check_value("rstmid_byte1", bus.tx_data, 8'h33);
    #2;
    RST = 1'b0;
    #1;
    check_value("rstmid_tx_valid_async", bus.tx_valid, 0);
    check_value("rstmid_busy_async", bus.busy, 0);
    check_value("rstmid_tx_data_async", bus.tx_data, 0);
    cyc();
    RST = 1'b1;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) early++;
      cyc();
    end
    check_value("rstmid_no_rsp", early, 0);
    issue(CMD_RF_WR, 8'h11, 8'h22, 8'h00, 4'h0, 1'b0);
    send_frame(3, 8'hAA, 8'h11, 8'h22, 8'h00, 1'b0);
    check_value("post_rst_rsp_valid", bus.rsp_valid, 1);
    check_value("post_rst_rsp_data", bus.rsp_data, 32'h0000);
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sys_cmd_master
`default_nettype wire
